canny_stage_scheduler: RTL and testbench

Frame-level sequencer for the 4-stage Canny pipeline (gauss 9x9 → gradient 7x7 → suppression 5x5 → hysteresis 3x3). Raster-walks the padded 520x520 input across the nine read SRAMs and pushes a column-valid token down a 5-deep enable chain so each stage fires exactly when its window holds live data. It also issues the write SRAM address/strobe and the end-of-frame dump. It sits between the top-level start/error pins and the SRAM/stage datapath.

---
 rtl/canny_stage_scheduler_pkg.sv | 22 ++
 rtl/canny_stage_scheduler_if.sv | 23 ++
 rtl/canny_stage_scheduler_token_chain.sv | 33 +++
 rtl/canny_stage_scheduler.sv | 140 ++++++++++++++
 tb/tb_canny_stage_scheduler.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/canny_stage_scheduler_pkg.sv
// Shared constants, FSM state type and column-token record for the Canny frame scheduler.
package canny_pkg;

  localparam int IN_W       = 520;
  localparam int OUT_W      = 512;
  localparam int WIN        = 9;
  localparam int PIPE_DEPTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [8:0] row;
    logic [9:0] col;
  } token_t;

endpackage

// File: rtl/canny_stage_scheduler_if.sv
// SRAM and stage-enable bus driven by the scheduler toward the Canny datapath.
interface canny_stage_scheduler_if;
  logic        read_enable_r;
  logic [18:0] add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i;
  logic        enable9x9, enable7x7, enable5x5, enable3x3;
  logic        write_enable_w;
  logic [17:0] write_address;
  logic        mem_dump_w;

  modport master (
    output read_enable_r,
    output add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i,
    output enable9x9, enable7x7, enable5x5, enable3x3,
    output write_enable_w, write_address, mem_dump_w
  );

  modport slave (
    input read_enable_r,
    input add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i,
    input enable9x9, enable7x7, enable5x5, enable3x3,
    input write_enable_w, write_address, mem_dump_w
  );
endinterface

// File: rtl/canny_stage_scheduler_token_chain.sv
// Fixed-depth shift register of column tokens; stage i output is the token from i+1 cycles ago.
module canny_token_chain
  import canny_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  token_t           tok_in,
  output logic [DEPTH-1:0] valid,
  output logic [8:0]       tail_row,
  output logic [9:0]       tail_col
);

  token_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tok_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = stage_q[i].valid;
  end

  assign tail_row = stage_q[DEPTH-1].row;
  assign tail_col = stage_q[DEPTH-1].col;

endmodule

// File: rtl/canny_stage_scheduler.sv
// Frame sequencer: raster read addressing, stage-enable token chain, write addressing and frame end.
// Optional feature macro: CANNY_SCHED_DUMP_EN (adds mem_dump_w pulse at FINISH).
module canny_stage_scheduler
  import canny_pkg::*;
#(
  parameter int IMG_W = OUT_W,
  parameter int IMG_H = OUT_W,
  parameter int PAD   = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  output logic                           error,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           gauss_fill_done,
  output logic                           grad_fill_done,
  output logic                           supp_fill_done,
  output logic                           hyst_fill_done,
  output logic [1:0]                     state_dbg,
  canny_stage_scheduler_if.master        bus
);

  localparam int          IN_COLS   = IMG_W + 2 * PAD;
  localparam logic [9:0]  LAST_COL  = 10'(IN_COLS - 1);
  localparam logic [9:0]  FIRST_COL = 10'(2 * PAD);
  localparam logic [8:0]  LAST_ROW  = 9'(IMG_H - 1);

  state_e     state;
  logic [8:0] row;
  logic [9:0] col;
  logic [3:0] fill_q;
  logic       start_ok;
  logic       read_en;
  token_t     tok0;
  logic [PIPE_DEPTH-1:0] tok_valid;
  logic [8:0] tail_row;
  logic [9:0] tail_col;
  logic [3:0] stage_en;
  logic [18:0] rd_addr [WIN];

  assign start_ok  = start && (state == IDLE);
  assign read_en   = (state == READ);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      error  <= 1'b0;
      fill_q <= '0;
    end else begin
      if (start_ok)   error <= 1'b0;
      else if (start) error <= 1'b1;

      if (start_ok) fill_q <= '0;
      else          fill_q <= fill_q | stage_en;

      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            row   <= '0;
            col   <= '0;
          end
        end
        READ: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) state <= DRAIN;
            else                 row   <= row + 9'd1;
          end else begin
            col <= col + 10'd1;
          end
        end
        // Leave once only the tail (write) stage can still hold a token, so the
        // final write lands in the last DRAIN cycle and FINISH follows it directly.
        DRAIN:   if (~|tok_valid[PIPE_DEPTH-2:0]) state <= FINISH;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < WIN; k++) begin : g_addr
    assign rd_addr[k] = read_en
      ? (19'(row) * 19'(IN_COLS) + 19'(k * IN_COLS) + 19'(col)) : '0;
  end

  assign tok0.valid = read_en && (col >= FIRST_COL);
  assign tok0.row   = row;
  assign tok0.col   = col;

  canny_token_chain #(.DEPTH(PIPE_DEPTH)) u_chain (
    .clk      (clk),
    .rst      (n_rst),
    .tok_in   (tok0),
    .valid    (tok_valid),
    .tail_row (tail_row),
    .tail_col (tail_col)
  );

  assign stage_en = tok_valid[3:0];

  assign bus.read_enable_r = read_en;
  assign bus.add_a = rd_addr[0];
  assign bus.add_b = rd_addr[1];
  assign bus.add_c = rd_addr[2];
  assign bus.add_d = rd_addr[3];
  assign bus.add_e = rd_addr[4];
  assign bus.add_f = rd_addr[5];
  assign bus.add_g = rd_addr[6];
  assign bus.add_h = rd_addr[7];
  assign bus.add_i = rd_addr[8];

  assign bus.enable9x9      = tok_valid[0];
  assign bus.enable7x7      = tok_valid[1];
  assign bus.enable5x5      = tok_valid[2];
  assign bus.enable3x3      = tok_valid[3];
  assign bus.write_enable_w = tok_valid[4];
  assign bus.write_address  = tok_valid[4]
    ? (18'(tail_row) * 18'(IMG_W) + 18'(tail_col) - 18'(FIRST_COL)) : '0;

  assign busy       = (state == READ) || (state == DRAIN);
  assign frame_done = (state == FINISH);

  // Flags include the live enable so a stage reads as filled in its first active cycle.
  assign gauss_fill_done = (state != IDLE) && (fill_q[0] || stage_en[0]);
  assign grad_fill_done  = (state != IDLE) && (fill_q[1] || stage_en[1]);
  assign supp_fill_done  = (state != IDLE) && (fill_q[2] || stage_en[2]);
  assign hyst_fill_done  = (state != IDLE) && (fill_q[3] || stage_en[3]);

`ifdef CANNY_SCHED_DUMP_EN
  assign bus.mem_dump_w = (state == FINISH);
`else
  assign bus.mem_dump_w = 1'b0;
`endif

endmodule

// File: tb/tb_canny_stage_scheduler.sv
// Randomized frame-level bench for canny_stage_scheduler on a reduced image size.
module tb_canny_stage_scheduler;

  localparam int W      = 16;
  localparam int H      = 5;
  localparam int PD     = 4;
  localparam int IN     = W + 2 * PD;
  localparam int FC     = 2 * PD;
  localparam int NREAD  = H * IN;
  localparam int DONE_N = NREAD + 6;

  logic clk;
  logic n_rst;
  logic start;
  logic error, busy, frame_done;
  logic gauss_fill_done, grad_fill_done, supp_fill_done, hyst_fill_done;
  logic [1:0] state_dbg;

  canny_stage_scheduler_if bus_if ();

  canny_stage_scheduler #(.IMG_W(W), .IMG_H(H), .PAD(PD)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .start           (start),
    .error           (error),
    .busy            (busy),
    .frame_done      (frame_done),
    .gauss_fill_done (gauss_fill_done),
    .grad_fill_done  (grad_fill_done),
    .supp_fill_done  (supp_fill_done),
    .hyst_fill_done  (hyst_fill_done),
    .state_dbg       (state_dbg),
    .bus             (bus_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: frame_n = 0 when idle, else 1-based cycle index since start accepted
  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int frame_n  = 0;
  bit err_exp  = 0;
  int wr_cnt   = 0;
  int last_wa  = -1;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d frame_n=%0d got=%0d exp=%0d", tag, cycle, frame_n, got, exp);
    end
  endtask

  function automatic logic [18:0] dut_addr(input int k);
    case (k)
      0: return bus_if.add_a;
      1: return bus_if.add_b;
      2: return bus_if.add_c;
      3: return bus_if.add_d;
      4: return bus_if.add_e;
      5: return bus_if.add_f;
      6: return bus_if.add_g;
      7: return bus_if.add_h;
      default: return bus_if.add_i;
    endcase
  endfunction

  // A read at frame cycle m carries a live column when m is a read cycle with col >= 2*PAD
  function automatic bit tok_live(input int m);
    return (m >= 1) && (m <= NREAD) && (((m - 1) % IN) >= FC);
  endfunction

  task automatic check_cycle();
    int  n;
    bit  rd;
    int  r, c, m;
    logic [3:0] en_exp, en_got, fill_exp, fill_got;
    n  = frame_n;
    rd = (n >= 1) && (n <= NREAD);
    r  = rd ? (n - 1) / IN : 0;
    c  = rd ? (n - 1) % IN : 0;
    check("read_enable", bus_if.read_enable_r, rd);
    for (int k = 0; k < 9; k++)
      check($sformatf("add_%0d", k), dut_addr(k), rd ? (r + k) * IN + c : 0);

    for (int s = 1; s <= 4; s++) begin
      en_exp[s-1]   = tok_live(n - s);
      fill_exp[s-1] = (n >= 1) && (n >= FC + 1 + s);
    end
    en_got   = {bus_if.enable3x3, bus_if.enable5x5, bus_if.enable7x7, bus_if.enable9x9};
    fill_got = {hyst_fill_done, supp_fill_done, grad_fill_done, gauss_fill_done};
    check("stage_enables", en_got, en_exp);
    check("fill_flags", fill_got, fill_exp);

    // scoreboard for write strobes
    m = n - 5;
    if (tok_live(m)) exp_q.push_back(18'(((m - 1) / IN) * W + ((m - 1) % IN) - FC));
    if (bus_if.write_enable_w) begin
      wr_cnt++;
      last_wa = int'(bus_if.write_address);
      if (exp_q.size() == 0) check("write_unexpected", 1, 0);
      else check("write_address", bus_if.write_address, exp_q.pop_front());
    end
    check("write_missing", exp_q.size(), 0);

    check("busy", busy, (n >= 1) && (n <= NREAD + 5));
    check("frame_done", frame_done, n == DONE_N);
`ifdef CANNY_SCHED_DUMP_EN
    check("mem_dump_w", bus_if.mem_dump_w, n == DONE_N);
`else
    check("mem_dump_w", bus_if.mem_dump_w, 0);
`endif
    check("error", error, err_exp);
    if (n == DONE_N) begin
      check("write_count", wr_cnt, W * H);
      check("last_write_address", last_wa, W * H - 1);
    end
  endtask

  task automatic model_update(input bit s, input bit r);
    if (r) begin
      frame_n = 0;
      err_exp = 0;
      exp_q.delete();
    end else begin
      if (s && frame_n != 0) err_exp = 1;
      if (frame_n == 0) begin
        if (s) begin
          frame_n = 1;
          err_exp = 0;
          wr_cnt  = 0;
          last_wa = -1;
        end
      end else if (frame_n == DONE_N) begin
        frame_n = 0;
      end else begin
        frame_n++;
      end
    end
  endtask

  // driver: observe the current cycle, then set inputs for the coming edge
  task automatic step(input bit s, input bit r);
    @(negedge clk);
    cycle++;
    if (cycle > 20000) begin
      $display("FAIL timeout cycle=%0d", cycle);
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
      $fatal(1);
    end
    check_cycle();
    start = s;
    n_rst = r;
    model_update(s, r);
  endtask

  initial begin
    n_rst = 1'b1;
    start = 1'b0;
    model_update(1'b0, 1'b1);
    repeat (3) step(0, 1);
    repeat (3) step(0, 0);

    // frame with a stray start at row 3, then start in FINISH, then start in IDLE
    step(1, 0);
    while (frame_n != 3 * IN + 6) step(0, 0);
    step(1, 0);
    while (frame_n != DONE_N) step(0, 0);
    step(1, 0);
    step(1, 0);

    // abort mid-frame at row 2, col 10
    while (frame_n != 2 * IN + 11) step(0, 0);
    step(0, 1);
    repeat (12) step(0, 0);

    // randomized frames with occasional stray starts and resets
    for (int f = 0; f < 6; f++) begin
      int gap;
      gap = $urandom_range(0, 4);
      repeat (gap) step(0, 0);
      step(1, 0);
      while (frame_n != 0) begin
        bit s, r;
        s = ($urandom_range(0, 63) == 0);
        r = ($urandom_range(0, 499) == 0);
        step(s, r);
      end
    end
    repeat (4) step(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
